instr_dec_buf: RTL and testbench

INSTR_DEC_BUF -- requirements
Module: instr_dec_buf

---
 rtl/instr_dec_buf_pkg.sv | 13 +
 rtl/instr_fifo.sv | 54 +++++
 rtl/instr_dec_buf.sv | 84 ++++++++
 tb/tb_instr_dec_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dec_buf_pkg.sv
// Shared attributes for the instruction decode buffer: default field widths,
// field positions inside the {opcode, b, c} word and the output-stage state type.
package instr_dec_buf_pkg;
   localparam int OP_WIDTH_DEF    = 4;
   localparam int REG_WIDTH_DEF   = 4;
   localparam int INSTR_WIDTH_DEF = OP_WIDTH_DEF + 2*REG_WIDTH_DEF;

   localparam int C_LSB      = 0;
   localparam int B_LSB_DEF  = C_LSB + REG_WIDTH_DEF;
   localparam int OP_LSB_DEF = B_LSB_DEF + REG_WIDTH_DEF;

   typedef enum logic {ST_EMPTY = 1'b0, ST_VALID = 1'b1} out_state_t;
endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue with occupancy count; clear wins over push/pop.
// Storage is not reset, only the pointers and the count.
module instr_fifo #(
   parameter  int WIDTH = 12,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/instr_dec_buf.sv
// Instruction queue feeding a single registered output stage that splits the
// word into opcode/b/c and flags opcodes outside the implemented range.
module instr_dec_buf
   import instr_dec_buf_pkg::*;
#(
   parameter  int OP_WIDTH    = OP_WIDTH_DEF,
   parameter  int REG_WIDTH   = REG_WIDTH_DEF,
   parameter  int DEPTH       = 4,
   parameter  int NUM_OPS     = 12,
   localparam int INSTR_WIDTH = OP_WIDTH + 2*REG_WIDTH,
   localparam int CW          = $clog2(DEPTH+1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   triggered,
   output logic                   indicate_busy,
   input  logic                   flush,
   input  logic                   check_busy,
   output logic                   trigger,
   output logic [OP_WIDTH-1:0]    opcode,
   output logic [REG_WIDTH-1:0]   b,
   output logic [REG_WIDTH-1:0]   c,
   output logic                   illegal,
   output logic [CW-1:0]          count
);
   localparam int B_LSB  = C_LSB + REG_WIDTH;
   localparam int OP_LSB = B_LSB + REG_WIDTH;

   out_state_t             state, state_nxt;
   logic [INSTR_WIDTH-1:0] head, held;
   logic                   q_full, q_empty, push, pop, consume;

   // Full is registered occupancy, so a same-edge pop never makes room for a write
   assign indicate_busy = q_full;
   assign push          = triggered && !q_full && !flush;
   assign consume       = (state == ST_VALID) && !check_busy;
   assign pop           = !flush && !q_empty && ((state == ST_EMPTY) || consume);

   instr_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push),
      .wdata (instr),
      .pop   (pop),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (!q_empty) state_nxt = ST_VALID;
            ST_VALID: if (consume && q_empty) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   held <= '0;
      else if (pop) held <= head;
   end

   always_comb begin
      trigger = (state == ST_VALID);
      opcode  = held[OP_LSB +: OP_WIDTH];
      b       = held[B_LSB +: REG_WIDTH];
      c       = held[C_LSB +: REG_WIDTH];
      illegal = (state == ST_VALID) &&
                ({1'b0, held[OP_LSB +: OP_WIDTH]} >= (OP_WIDTH+1)'(NUM_OPS));
   end
endmodule

// File: tb/tb_instr_dec_buf.sv
// Bench for instr_dec_buf: directed scenarios plus a randomized run, all
// checked against a queue-level model of the decode buffer.
module tb_instr_dec_buf;
   import instr_dec_buf_pkg::*;

   localparam int DEPTH   = 4;
   localparam int NUM_OPS = 12;
   localparam int IW      = INSTR_WIDTH_DEF;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [IW-1:0] instr = '0;
   logic          triggered = 1'b0, flush = 1'b0, check_busy = 1'b0;
   logic          indicate_busy, trigger, illegal;
   logic [3:0]    opcode, b, c;
   logic [2:0]    count;

   int checks = 0, errors = 0;

   // model: pending words in write order plus the word shown on the outputs
   int mq[$];
   int m_held = 0;
   bit m_vld  = 1'b0;

   always #5 clk = ~clk;

   instr_dec_buf #(.DEPTH(DEPTH), .NUM_OPS(NUM_OPS)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .triggered(triggered),
      .indicate_busy(indicate_busy), .flush(flush), .check_busy(check_busy),
      .trigger(trigger), .opcode(opcode), .b(b), .c(c), .illegal(illegal),
      .count(count)
   );

   function automatic logic [11:0] f_word(input int w);
      return 12'(w);
   endfunction

   task automatic step(input bit trg, input int ins, input bit cb, input bit fl);
      bit full, consume, take;
      triggered = trg; instr = IW'(ins); check_busy = cb; flush = fl;
      @(posedge clk);
      full = (mq.size() == DEPTH);
      if (fl) begin
         mq.delete();
         m_vld = 1'b0;
      end else begin
         consume = m_vld && !cb;
         take    = (!m_vld || consume) && (mq.size() > 0);
         if (take) begin
            m_held = mq.pop_front();
            m_vld  = 1'b1;
         end else if (consume) begin
            m_vld = 1'b0;
         end
         if (trg && !full) mq.push_back(ins & 'hFFF);
      end
      #1;
      triggered = 1'b0; flush = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      m_vld = 1'b0; m_held = 0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({trigger, indicate_busy, illegal} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {trigger, indicate_busy, illegal});
      end
      checks++;
      if ({count, opcode, b, c} !== 15'd0) begin
         errors++; $display("FAIL reset_fields: got %h want 0", {count, opcode, b, c});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_decode();
      step(1, 2048, 0, 0);
      checks++;
      if (trigger !== 1'b0) begin errors++; $display("FAIL decode_latency1: got %b want 0", trigger); end
      step(0, 0, 0, 0);
      checks++;
      if ({trigger, opcode, b, c, illegal} !== {1'b1, 4'd8, 4'd0, 4'd0, 1'b0}) begin
         errors++; $display("FAIL decode_2048: got t=%b op=%0d b=%0d c=%0d ill=%b want t=1 op=8 b=0 c=0 ill=0",
                            trigger, opcode, b, c, illegal);
      end
      step(0, 0, 0, 0);
      checks++;
      if (trigger !== 1'b0) begin errors++; $display("FAIL decode_one_cycle: got %b want 0", trigger); end
   endtask

   task automatic test_fields();
      step(1, 1656, 0, 0);
      step(1, 'hF00, 0, 0);
      checks++;
      if ({trigger, opcode, b, c, illegal} !== {1'b1, 4'd6, 4'd7, 4'd8, 1'b0}) begin
         errors++; $display("FAIL fields_1656: got t=%b op=%0d b=%0d c=%0d ill=%b want 1 6 7 8 0",
                            trigger, opcode, b, c, illegal);
      end
      step(0, 0, 0, 0);
      checks++;
      if ({trigger, opcode, illegal} !== {1'b1, 4'd15, 1'b1}) begin
         errors++; $display("FAIL fields_F00: got t=%b op=%0d ill=%b want 1 15 1", trigger, opcode, illegal);
      end
      step(0, 0, 0, 0);
      checks++;
      if (trigger !== 1'b0) begin errors++; $display("FAIL fields_drain: got %b want 0", trigger); end
   endtask

   task automatic test_full_stall();
      for (int v = 1; v <= 6; v++) step(1, v, 1, 0);
      checks++;
      if ({count, indicate_busy, trigger} !== {3'd4, 1'b1, 1'b1}) begin
         errors++; $display("FAIL full_state: got cnt=%0d busy=%b t=%b want 4 1 1", count, indicate_busy, trigger);
      end
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if ({trigger, opcode, b, c} !== {1'b1, f_word(k)}) begin
            errors++; $display("FAIL full_issue_%0d: got t=%b word=%h want t=1 word=%h", k, trigger, {opcode, b, c}, f_word(k));
         end
         step(0, 0, 0, 0);
      end
      checks++;
      if ({trigger, count} !== 4'b0000) begin
         errors++; $display("FAIL full_drop6: got t=%b cnt=%0d want 0 0", trigger, count);
      end
   endtask

   task automatic test_stall_toggle();
      int wr[$];
      int got[$];
      logic [11:0] prev = '0;
      bit prev_hold = 1'b0;
      bit cb;
      for (int i = 0; i < 5; i++) begin
         wr.push_back(int'($urandom_range(0, 4095)));
         step(1, wr[i], 1, 0);
      end
      for (int i = 0; i < 40 && got.size() < 5; i++) begin
         cb = (i % 2 == 0);
         if (prev_hold) begin
            checks++;
            if ({trigger, opcode, b, c} !== {1'b1, prev}) begin
               errors++; $display("FAIL stall_hold: got t=%b word=%h want t=1 word=%h", trigger, {opcode, b, c}, prev);
            end
         end
         if (trigger && !cb) got.push_back(int'({opcode, b, c}));
         prev      = {opcode, b, c};
         prev_hold = trigger && cb;
         step(0, 0, cb, 0);
      end
      checks++;
      if (got.size() !== 5) begin
         errors++; $display("FAIL stall_count: got %0d issues want 5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== wr[i]) begin
               errors++; $display("FAIL stall_order_%0d: got %h want %h", i, got[i], wr[i]);
            end
         end
      end
      step(0, 0, 0, 0);
   endtask

   task automatic test_flush();
      for (int v = 0; v < 4; v++) step(1, 'h100 + v, 1, 0);
      checks++;
      if ({count, trigger} !== {3'd3, 1'b1}) begin
         errors++; $display("FAIL flush_setup: got cnt=%0d t=%b want 3 1", count, trigger);
      end
      step(1, 'h123, 1, 1);
      checks++;
      if ({count, trigger, indicate_busy} !== {3'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL flush_clear: got cnt=%0d t=%b busy=%b want 0 0 0", count, trigger, indicate_busy);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         checks++;
         if ({trigger, count} !== 4'b0000) begin
            errors++; $display("FAIL flush_dropped_%0d: got t=%b cnt=%0d want 0 0", i, trigger, count);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int v = 0; v < 3; v++) step(1, 'h200 + v, 1, 0);
      checks++;
      if ({count, trigger} !== {3'd2, 1'b1}) begin
         errors++; $display("FAIL rstmid_setup: got cnt=%0d t=%b want 2 1", count, trigger);
      end
      #2; rst_n = 1'b0; #1;
      checks++;
      if ({trigger, indicate_busy, illegal, count, opcode, b, c} !== 18'd0) begin
         errors++; $display("FAIL rstmid_zero: got %h want 0", {trigger, indicate_busy, illegal, count, opcode, b, c});
      end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      step(1, 'h345, 0, 0);
      checks++;
      if ({trigger, count} !== {1'b0, 3'd1}) begin
         errors++; $display("FAIL rstmid_accept: got t=%b cnt=%0d want 0 1", trigger, count);
      end
      step(0, 0, 0, 0);
      checks++;
      if ({trigger, opcode, b, c, illegal} !== {1'b1, 12'h345, 1'b0}) begin
         errors++; $display("FAIL rstmid_issue: got t=%b word=%h ill=%b want 1 345 0", trigger, {opcode, b, c}, illegal);
      end
      step(0, 0, 0, 0);
   endtask

   task automatic test_random();
      bit trg, cb, fl;
      for (int i = 0; i < 600; i++) begin
         // phases bias toward filling (mostly stalled) or draining
         trg = ($urandom_range(0, 3) != 0);
         cb  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 40) == 0);
         step(trg, int'($urandom_range(0, 4095)), cb, fl);
         checks++;
         if ({trigger, count, indicate_busy} !== {m_vld, 3'(mq.size()), (mq.size() == DEPTH)}) begin
            errors++; $display("FAIL rand_state_%0d: got t=%b cnt=%0d busy=%b want t=%b cnt=%0d busy=%b",
                               i, trigger, count, indicate_busy, m_vld, mq.size(), (mq.size() == DEPTH));
         end
         if (m_vld) begin
            checks++;
            if ({opcode, b, c, illegal} !== {f_word(m_held), ((m_held >> OP_LSB_DEF) >= NUM_OPS)}) begin
               errors++; $display("FAIL rand_word_%0d: got word=%h ill=%b want word=%h ill=%b", i,
                                  {opcode, b, c}, illegal, f_word(m_held), ((m_held >> OP_LSB_DEF) >= NUM_OPS));
            end
            checks++;
            if (b !== 4'((m_held >> B_LSB_DEF) & 'hF)) begin
               errors++; $display("FAIL rand_b_%0d: got %0d want %0d", i, b, (m_held >> B_LSB_DEF) & 'hF);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_fields();
      test_full_stall();
      test_stall_toggle();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
